// File: rtl/text_attribute_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_attribute_renderer_pkg
// Description : Shared constants for the text-mode renderer: default text
//               geometry and the attribute word layout
//               {rev, ul, blink, bg, fg, char[7:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package text_attribute_renderer_pkg;

    // Default text geometry (800x600-class text mode)
    localparam int c_DEF_COLOR_BITS  = 1;
    localparam int c_DEF_CHAR_WIDTH  = 8;
    localparam int c_DEF_CHAR_HEIGHT = 16;
    localparam int c_DEF_TEXT_COLS   = 100;
    localparam int c_DEF_TEXT_ROWS   = 37;

    // Attribute word width: 8 char bits + fg + bg + 3 flag bits
    function automatic int attr_w(input int cb);
        return 11 + 6 * cb;
    endfunction

    // Field offsets inside the attribute word
    function automatic int attr_char_lsb(input int cb);
        return 0 * cb;
    endfunction

    function automatic int attr_fg_lsb(input int cb);
        return 8 + 0 * cb;
    endfunction

    function automatic int attr_bg_lsb(input int cb);
        return 8 + 3 * cb;
    endfunction

    function automatic int attr_blink_bit(input int cb);
        return 8 + 6 * cb;
    endfunction

    function automatic int attr_ul_bit(input int cb);
        return 9 + 6 * cb;
    endfunction

    function automatic int attr_rev_bit(input int cb);
        return 10 + 6 * cb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_blink_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_blink_counter
// Description : Counts frame ticks 0..FRAMES-1 and toggles a phase bit on
//               each wrap. Phase comes out of reset at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_blink_counter #(
    parameter int FRAMES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    output logic phase
);

    localparam int              c_CW   = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(FRAMES - 1);

    logic [c_CW-1:0] r_count;
    logic            r_phase;

    // Advance on each frame tick; wrap toggles the phase
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else if (tick) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/text_attribute_renderer.sv
`default_nettype none
// ============================================================================
// Module      : text_attribute_renderer
// Description : Text-mode pixel pipeline. Issues the video memory request,
//               then the glyph ROM request, then resolves reverse, underline,
//               blink and cursor into registered RGB. Sync and drawing flags
//               travel alongside so everything leaves aligned after
//               L = MEM_LATENCY + GLYPH_LATENCY + 1 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module text_attribute_renderer
    import text_attribute_renderer_pkg::*;
#(
    parameter int   COLOR_BITS    = c_DEF_COLOR_BITS,
    parameter int   CHAR_WIDTH    = c_DEF_CHAR_WIDTH,
    parameter int   CHAR_HEIGHT   = c_DEF_CHAR_HEIGHT,
    parameter int   TEXT_COLS     = c_DEF_TEXT_COLS,
    parameter int   TEXT_ROWS     = c_DEF_TEXT_ROWS,
    parameter int   MEM_LATENCY   = 1,
    parameter int   GLYPH_LATENCY = 1,
    parameter int   BLINK_FRAMES  = 32,
    parameter int   CURSOR_FRAMES = 16,
    parameter logic SYNC_ACTIVE   = 1'b1,
    localparam int  CXW           = $clog2(CHAR_WIDTH),
    localparam int  CYW           = $clog2(CHAR_HEIGHT),
    localparam int  TXW           = $clog2(TEXT_COLS),
    localparam int  TYW           = $clog2(TEXT_ROWS),
    localparam int  ATTR_W        = attr_w(COLOR_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  drawing_in,
    input  logic [CXW-1:0]        xchar,
    input  logic [CYW-1:0]        ychar,
    input  logic [TXW-1:0]        xtext,
    input  logic [TYW-1:0]        ytext,
    output logic [TXW+TYW-1:0]    mem_addr,
    input  logic [ATTR_W-1:0]     mem_attr,
    output logic [7:0]            glyph_index,
    output logic [CYW-1:0]        glyph_row,
    input  logic [CHAR_WIDTH-1:0] glyph_bits,
    input  logic                  cursor_en,
    input  logic [TXW-1:0]        cursor_x,
    input  logic [TYW-1:0]        cursor_y,
    input  logic [CYW-1:0]        cursor_top,
    input  logic [CYW-1:0]        cursor_bot,
    output logic                  hsync,
    output logic                  vsync,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CB         = COLOR_BITS;
    localparam int c_COL_W      = 3 * COLOR_BITS;
    localparam int c_CHAR_LSB   = attr_char_lsb(COLOR_BITS);
    localparam int c_FG_LSB     = attr_fg_lsb(COLOR_BITS);
    localparam int c_BG_LSB     = attr_bg_lsb(COLOR_BITS);
    localparam int c_BLINK_BIT  = attr_blink_bit(COLOR_BITS);
    localparam int c_UL_BIT     = attr_ul_bit(COLOR_BITS);
    localparam int c_REV_BIT    = attr_rev_bit(COLOR_BITS);

    // Sideband delay line: {hsync, vsync, drawing, cursor_cell, ychar, xchar}
    localparam int c_SIDE_DEPTH = MEM_LATENCY + GLYPH_LATENCY;
    localparam int c_SIDE_W     = 4 + CXW + CYW;
    localparam int c_XC_LSB     = 0;
    localparam int c_YC_LSB     = CXW;
    localparam int c_CUR_BIT    = CXW + CYW;
    localparam int c_DRAW_BIT   = CXW + CYW + 1;
    localparam int c_VS_BIT     = CXW + CYW + 2;
    localparam int c_HS_BIT     = CXW + CYW + 3;

    // Syncs idle, drawing off, no cursor while the line refills
    localparam logic [c_SIDE_W-1:0] c_SIDE_RST =
        {~SYNC_ACTIVE, ~SYNC_ACTIVE, {(c_SIDE_W - 2){1'b0}}};
    localparam logic [CYW-1:0] c_LAST_ROW = CYW'(CHAR_HEIGHT - 1);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                  r_vs_prev;
    logic                  r_vs_seen;
    logic                  w_tick;

    logic                  r_cur_en;
    logic [TXW-1:0]        r_cur_x;
    logic [TYW-1:0]        r_cur_y;
    logic [CYW-1:0]        r_cur_top;
    logic [CYW-1:0]        r_cur_bot;

    logic                  w_blink_phase;
    logic                  w_cursor_phase;

    logic                  w_cell_is_cursor;
    logic [c_SIDE_W-1:0]   w_side_in;
    logic [c_SIDE_W-1:0]   r_side [c_SIDE_DEPTH];
    logic [c_SIDE_W-1:0]   w_side_c;

    logic [TXW+TYW-1:0]    r_mem_addr;
    logic [7:0]            r_glyph_index;
    logic [CYW-1:0]        r_glyph_row;
    logic [ATTR_W-1:0]     r_attr_d [GLYPH_LATENCY];
    logic [ATTR_W-1:0]     w_attr_c;

    logic [CHAR_WIDTH-1:0] w_glyph_rev;
    logic [CXW-1:0]        w_xchar_c;
    logic [CYW-1:0]        w_ychar_c;
    logic                  w_pix;
    logic                  w_cursor_hit;
    logic                  w_on;
    logic [c_COL_W-1:0]    w_fg_eff;
    logic [c_COL_W-1:0]    w_bg_eff;
    logic [c_COL_W-1:0]    w_rgb;

    logic                  r_hsync;
    logic                  r_vsync;
    logic [c_CB-1:0]       r_red;
    logic [c_CB-1:0]       r_green;
    logic [c_CB-1:0]       r_blue;

    // ------------------------------------------------------------------
    // Frame tick: vsync_in entering its active level, only once a valid
    // idle sample has been seen since reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev <= ~SYNC_ACTIVE;
            r_vs_seen <= 1'b0;
        end else begin
            r_vs_prev <= vsync_in;
            r_vs_seen <= 1'b1;
        end
    end

    assign w_tick = r_vs_seen && (vsync_in == SYNC_ACTIVE) && (r_vs_prev != SYNC_ACTIVE);

    // Cursor settings are sampled only at frame start so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_en  <= 1'b0;
            r_cur_x   <= '0;
            r_cur_y   <= '0;
            r_cur_top <= '0;
            r_cur_bot <= '0;
        end else if (w_tick) begin
            r_cur_en  <= cursor_en;
            r_cur_x   <= cursor_x;
            r_cur_y   <= cursor_y;
            r_cur_top <= cursor_top;
            r_cur_bot <= cursor_bot;
        end
    end

    frame_blink_counter #(
        .FRAMES (BLINK_FRAMES)
    ) u_text_blink (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick),
        .phase (w_blink_phase)
    );

    frame_blink_counter #(
        .FRAMES (CURSOR_FRAMES)
    ) u_cursor_blink (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick),
        .phase (w_cursor_phase)
    );

    // ------------------------------------------------------------------
    // Stage A: memory request and sideband capture
    // ------------------------------------------------------------------
    assign w_cell_is_cursor = (xtext == r_cur_x) && (ytext == r_cur_y);
    assign w_side_in = {hsync_in, vsync_in, drawing_in, w_cell_is_cursor, ychar, xchar};

    // Memory address register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr <= '0;
        end else begin
            r_mem_addr <= {ytext, xtext};
        end
    end

    // Sideband shift register spanning memory and glyph latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_SIDE_DEPTH; i++) begin
                r_side[i] <= c_SIDE_RST;
            end
        end else begin
            r_side[0] <= w_side_in;
            for (int i = 1; i < c_SIDE_DEPTH; i++) begin
                r_side[i] <= r_side[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: glyph request; attribute held until glyph row returns
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_glyph_index <= '0;
            r_glyph_row   <= '0;
        end else begin
            r_glyph_index <= mem_attr[c_CHAR_LSB +: 8];
            r_glyph_row   <= r_side[MEM_LATENCY-1][c_YC_LSB +: CYW];
        end
    end

    // Attribute shift register spanning glyph latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < GLYPH_LATENCY; i++) begin
                r_attr_d[i] <= '0;
            end
        end else begin
            r_attr_d[0] <= mem_attr;
            for (int i = 1; i < GLYPH_LATENCY; i++) begin
                r_attr_d[i] <= r_attr_d[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage C: pixel select and attribute resolution
    // ------------------------------------------------------------------
    assign w_side_c  = r_side[c_SIDE_DEPTH-1];
    assign w_attr_c  = r_attr_d[GLYPH_LATENCY-1];
    assign w_xchar_c = w_side_c[c_XC_LSB +: CXW];
    assign w_ychar_c = w_side_c[c_YC_LSB +: CYW];

    // Mirror the glyph row so xchar indexes it directly (MSB is leftmost)
    always_comb begin
        w_glyph_rev = '0;
        for (int i = 0; i < CHAR_WIDTH; i++) begin
            w_glyph_rev[i] = glyph_bits[CHAR_WIDTH-1-i];
        end
    end

    assign w_pix = w_glyph_rev[w_xchar_c];

    // Reverse, underline, blink, cursor, then blanking outside drawing
    always_comb begin
        w_fg_eff = w_attr_c[c_FG_LSB +: c_COL_W];
        w_bg_eff = w_attr_c[c_BG_LSB +: c_COL_W];
        if (w_attr_c[c_REV_BIT]) begin
            w_fg_eff = w_attr_c[c_BG_LSB +: c_COL_W];
            w_bg_eff = w_attr_c[c_FG_LSB +: c_COL_W];
        end

        w_on = w_pix | (w_attr_c[c_UL_BIT] & (w_ychar_c == c_LAST_ROW));
        if (w_attr_c[c_BLINK_BIT] && !w_blink_phase) begin
            w_on = 1'b0;
        end

        // An inverted range (top > bot) simply never matches
        w_cursor_hit = r_cur_en && w_side_c[c_CUR_BIT] &&
                       (w_ychar_c >= r_cur_top) && (w_ychar_c <= r_cur_bot);
        w_on = w_on ^ (w_cursor_hit & w_cursor_phase);

        w_rgb = w_on ? w_fg_eff : w_bg_eff;
        if (!w_side_c[c_DRAW_BIT]) begin
            w_rgb = '0;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= ~SYNC_ACTIVE;
            r_vsync <= ~SYNC_ACTIVE;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else begin
            r_hsync <= w_side_c[c_HS_BIT];
            r_vsync <= w_side_c[c_VS_BIT];
            r_red   <= w_rgb[0      +: c_CB];
            r_green <= w_rgb[c_CB   +: c_CB];
            r_blue  <= w_rgb[2*c_CB +: c_CB];
        end
    end

    assign mem_addr    = r_mem_addr;
    assign glyph_index = r_glyph_index;
    assign glyph_row   = r_glyph_row;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_text_attribute_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_attribute_renderer
// Description : Scoreboard bench for text_attribute_renderer with
//               COLOR_BITS=2, MEM_LATENCY=2, GLYPH_LATENCY=1 (L=4),
//               BLINK_FRAMES=2, CURSOR_FRAMES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_attribute_renderer;

    localparam int c_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in, drawing_in;
    logic [2:0]  xchar;
    logic [3:0]  ychar;
    logic [6:0]  xtext;
    logic [5:0]  ytext;
    logic [12:0] mem_addr;
    logic [22:0] mem_attr;
    logic [7:0]  glyph_index;
    logic [3:0]  glyph_row;
    logic [7:0]  glyph_bits;
    logic        cursor_en;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic [3:0]  cursor_top, cursor_bot;
    logic        hsync, vsync;
    logic [1:0]  red, green, blue;

    text_attribute_renderer #(
        .COLOR_BITS    (2),
        .MEM_LATENCY   (2),
        .GLYPH_LATENCY (1),
        .BLINK_FRAMES  (2),
        .CURSOR_FRAMES (1),
        .SYNC_ACTIVE   (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .drawing_in  (drawing_in),
        .xchar       (xchar),
        .ychar       (ychar),
        .xtext       (xtext),
        .ytext       (ytext),
        .mem_addr    (mem_addr),
        .mem_attr    (mem_attr),
        .glyph_index (glyph_index),
        .glyph_row   (glyph_row),
        .glyph_bits  (glyph_bits),
        .cursor_en   (cursor_en),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .cursor_top  (cursor_top),
        .cursor_bot  (cursor_bot),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 clk = ~clk;

    // Video memory with one read register (MEM_LATENCY=2), combinational glyph ROM
    logic [22:0] vram [0:8191];
    logic [7:0]  grom [0:4095];
    logic [22:0] r_mem_q;

    always @(posedge clk) r_mem_q <= vram[mem_addr];
    assign mem_attr   = r_mem_q;
    assign glyph_bits = grom[{glyph_index, glyph_row}];

    function automatic logic [22:0] mk_attr(input logic rev, input logic ul, input logic bl,
                                            input logic [5:0] bg, input logic [5:0] fg,
                                            input logic [7:0] ch);
        return {rev, ul, bl, bg, fg, ch};
    endfunction

    // Scoreboard
    typedef struct {
        int          due;
        string       name;
        logic [5:0]  col;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire every expectation that falls due this cycle
    always @(negedge clk) begin : mon
        exp_t e;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                e = q[i];
                q.delete(i);
                n_total++;
                if (e.due == cyc && {blue, green, red} === e.col &&
                    hsync === e.hs && vsync === e.vs) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got rgb=%h hs=%b vs=%b at cycle %0d, expected rgb=%h hs=%b vs=%b at cycle %0d",
                             e.name, {blue, green, red}, hsync, vsync, cyc, e.col, e.hs, e.vs, e.due);
                end
            end
        end
    end

    task automatic cyc_drive(input logic rst, input logic hs, input logic vs, input logic dr,
                             input int xt, input int yt, input int xc, input int yc);
        @(negedge clk);
        reset      = rst;
        hsync_in   = hs;
        vsync_in   = vs;
        drawing_in = dr;
        xtext      = 7'(xt);
        ytext      = 6'(yt);
        xchar      = 3'(xc);
        ychar      = 4'(yc);
    endtask

    task automatic expect_in(input int dly, input string nm, input logic [5:0] col,
                             input logic hs, input logic vs);
        exp_t e;
        e.due  = cyc + dly;
        e.name = nm;
        e.col  = col;
        e.hs   = hs;
        e.vs   = vs;
        q.push_back(e);
    endtask

    task automatic pix(input string nm, input int xt, input int yt, input int xc, input int yc,
                       input logic [5:0] col);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, xt, yt, xc, yc);
        expect_in(c_LAT, nm, col, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    // One vsync pulse, isolated from checked pixels by a full pipeline
    task automatic frame_tick();
        idle(c_LAT + 1);
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
        expect_in(c_LAT, "vsync_delay", 6'h00, 1'b0, 1'b1);
        idle(c_LAT + 1);
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, %0d checks made", n_total);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8192; i++) vram[i] = '0;
        for (int i = 0; i < 4096; i++) grom[i] = '0;
        for (int r = 0; r < 16; r++) begin
            grom[1*16 + r] = 8'b1000_0000;
            grom[2*16 + r] = 8'hFF;
        end
        vram[0*128 + 0] = mk_attr(1'b0, 1'b0, 1'b0, 6'h01, 6'b11_01_10, 8'd1);
        vram[0*128 + 1] = mk_attr(1'b1, 1'b1, 1'b0, 6'd5, 6'd2, 8'd0);
        vram[0*128 + 2] = mk_attr(1'b0, 1'b0, 1'b1, 6'h15, 6'h2A, 8'd2);
        vram[2*128 + 3] = mk_attr(1'b0, 1'b0, 1'b0, 6'h30, 6'h0F, 8'd0);
        vram[2*128 + 4] = mk_attr(1'b0, 1'b0, 1'b0, 6'h30, 6'h0F, 8'd0);

        cursor_en  = 1'b1;
        cursor_x   = 7'd3;
        cursor_y   = 6'd2;
        cursor_top = 4'd14;
        cursor_bot = 4'd15;

        // Reset: registered outputs clear one clock later
        for (int i = 0; i < 3; i++) begin
            cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
            expect_in(1, "reset_state", 6'h00, 1'b0, 1'b0);
        end
        idle(c_LAT + 1);

        // Pipeline alignment and channel mapping: lit pixel only at xchar=0
        for (int x = 0; x < 8; x++) begin
            cyc_drive(1'b0, (x == 0), 1'b0, 1'b1, 0, 0, x, 0);
            expect_in(c_LAT, $sformatf("align_x%0d", x), (x == 0) ? 6'b11_01_10 : 6'h01,
                      (x == 0), 1'b0);
        end
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        expect_in(c_LAT, "blank_not_drawing", 6'h00, 1'b0, 1'b0);

        // Reverse + underline, blank glyph
        for (int r = 0; r < 16; r++) begin
            pix($sformatf("rev_ul_row%0d", r), 1, 0, 3, r, (r == 15) ? 6'd5 : 6'd2);
        end

        // Frame 0: cursor not yet latched, blink visible
        pix("blink_f0", 2, 0, 0, 0, 6'h2A);
        pix("cursor_unlatched_f0", 3, 2, 0, 14, 6'h30);
        frame_tick();
        // Frame 1: cursor phase 0
        pix("blink_f1", 2, 0, 0, 0, 6'h2A);
        pix("cursor_phase0_f1", 3, 2, 0, 14, 6'h30);
        frame_tick();
        // Frame 2: cursor shown, blink hidden
        pix("blink_f2", 2, 0, 0, 0, 6'h15);
        pix("cursor_row14_f2", 3, 2, 0, 14, 6'h0F);
        pix("cursor_row15_f2", 3, 2, 5, 15, 6'h0F);
        pix("cursor_row13_f2", 3, 2, 0, 13, 6'h30);
        pix("cursor_other_cell_f2", 4, 2, 0, 14, 6'h30);
        cursor_x = 7'd4;
        pix("cursor_midframe_old", 3, 2, 0, 14, 6'h0F);
        pix("cursor_midframe_new", 4, 2, 0, 14, 6'h30);
        frame_tick();
        // Frame 3
        pix("blink_f3", 2, 0, 0, 0, 6'h15);
        pix("cursor_phase0_f3", 4, 2, 0, 14, 6'h30);
        frame_tick();
        // Frame 4: cursor moved to (4,2)
        pix("blink_f4", 2, 0, 0, 0, 6'h2A);
        pix("cursor_moved_f4", 4, 2, 0, 14, 6'h0F);
        pix("cursor_old_cell_f4", 3, 2, 0, 14, 6'h30);
        // Inverted scanline range: never shown
        cursor_top = 4'd15;
        cursor_bot = 4'd14;
        frame_tick();
        frame_tick();
        pix("cursor_inverted_row14", 4, 2, 0, 14, 6'h30);
        pix("cursor_inverted_row15", 4, 2, 0, 15, 6'h30);
        pix("blink_f6", 2, 0, 0, 0, 6'h15);
        idle(c_LAT + 1);

        // Reset mid-line: in-flight pixels are discarded
        for (int x = 0; x < 4; x++) cyc_drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, x, 0);
        cyc_drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 4, 0);
        expect_in(1, "reset_midline", 6'h00, 1'b0, 1'b0);
        cyc_drive(1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 0, 0);
        for (int d = 1; d < c_LAT; d++) begin
            expect_in(d, $sformatf("sync_hold_%0d", d), 6'h00, 1'b0, 1'b0);
        end
        expect_in(c_LAT, "post_reset_blink_visible", 6'h2A, 1'b1, 1'b0);
        idle(c_LAT + 3);

        if (q.size() != 0) begin
            for (int i = 0; i < q.size(); i++) begin
                n_total++;
                $display("FAIL %s: expectation due at cycle %0d never checked (now %0d)",
                         q[i].name, q[i].due, cyc);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
